// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the GPP load/store port and the
// communications processor (RX buffer writes, TX buffer reads).
//
// Ports:
//   clk, rst (async, active-low)
//   gpp_req/we/addr/wdata   -> gpp_gnt, gpp_stall, gpp_rvalid, gpp_rdata
//   cp_req/we/addr/wdata/last -> cp_gnt, cp_rvalid, cp_rdata
//   mem_addr/we/wdata out, mem_rdata in (valid one cycle after the address)
//
// Arbitration is per cycle. On a conflict, the requester that was not served
// last wins. A CP access with cp_last=0 locks the memory to the CP until
// cp_last, MAX_BURST beats, or cp_req drops.
module data_memory_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              gpp_req,
    input  logic              gpp_we,
    input  logic [ADDR_W-1:0] gpp_addr,
    input  logic [DATA_W-1:0] gpp_wdata,
    output logic              gpp_gnt,
    output logic              gpp_stall,
    output logic              gpp_rvalid,
    output logic [DATA_W-1:0] gpp_rdata,

    input  logic              cp_req,
    input  logic              cp_we,
    input  logic [ADDR_W-1:0] cp_addr,
    input  logic [DATA_W-1:0] cp_wdata,
    input  logic              cp_last,
    output logic              cp_gnt,
    output logic              cp_rvalid,
    output logic [DATA_W-1:0] cp_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic BURST_EN = (MAX_BURST > 1);

    typedef enum logic {
        IDLE,
        CP_BURST
    } state_e;

    state_e          state_q, state_d;
    logic            last_cp_q, last_cp_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            gpp_rvalid_q, gpp_rvalid_d;
    logic            cp_rvalid_q, cp_rvalid_d;
    logic [CW-1:0]   beat_inc;

    assign beat_inc = beat_cnt_q + CW'(1);

    // Grants and next state. Grants are held low while reset is asserted so
    // that a reset in the middle of a burst cuts the CP off immediately.
    always_comb begin
        state_d    = state_q;
        last_cp_d  = last_cp_q;
        beat_cnt_d = beat_cnt_q;
        gpp_gnt    = 1'b0;
        cp_gnt     = 1'b0;

        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (gpp_req && cp_req) begin
                        if (last_cp_q) gpp_gnt = 1'b1;
                        else           cp_gnt  = 1'b1;
                    end else if (gpp_req) begin
                        gpp_gnt = 1'b1;
                    end else if (cp_req) begin
                        cp_gnt = 1'b1;
                    end
                    if (cp_gnt && !cp_last && BURST_EN) begin
                        state_d    = CP_BURST;
                        beat_cnt_d = CW'(1);
                    end
                end
                CP_BURST: begin
                    if (cp_req) begin
                        cp_gnt     = 1'b1;
                        beat_cnt_d = beat_inc;
                        if (cp_last || beat_inc == MAX_CNT) begin
                            state_d    = IDLE;
                            beat_cnt_d = '0;
                        end
                    end else begin
                        // CP walked away mid-burst: release the lock.
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end
                end
            endcase

            if (gpp_gnt) last_cp_d = 1'b0;
            if (cp_gnt)  last_cp_d = 1'b1;
        end
    end

    // Memory port mux; idle cycles drive zeros.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (gpp_gnt) begin
            mem_addr  = gpp_addr;
            mem_we    = gpp_we;
            mem_wdata = gpp_wdata;
        end else if (cp_gnt) begin
            mem_addr  = cp_addr;
            mem_we    = cp_we;
            mem_wdata = cp_wdata;
        end
    end

    assign gpp_rvalid_d = gpp_gnt & ~gpp_we;
    assign cp_rvalid_d  = cp_gnt & ~cp_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_cp_q    <= 1'b1;
            beat_cnt_q   <= '0;
            gpp_rvalid_q <= 1'b0;
            cp_rvalid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_cp_q    <= last_cp_d;
            beat_cnt_q   <= beat_cnt_d;
            gpp_rvalid_q <= gpp_rvalid_d;
            cp_rvalid_q  <= cp_rvalid_d;
        end
    end

    assign gpp_stall  = gpp_req & ~gpp_gnt;
    assign gpp_rvalid = gpp_rvalid_q;
    assign cp_rvalid  = cp_rvalid_q;
    assign gpp_rdata  = mem_rdata;
    assign cp_rdata   = mem_rdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed testbench for data_memory_arbiter with a small synchronous
// memory model behind the memory port.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        gpp_req, gpp_we;
    logic [15:0] gpp_addr, gpp_wdata;
    logic        gpp_gnt, gpp_stall, gpp_rvalid;
    logic [15:0] gpp_rdata;
    logic        cp_req, cp_we, cp_last;
    logic [15:0] cp_addr, cp_wdata;
    logic        cp_gnt, cp_rvalid;
    logic [15:0] cp_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [15:0] mem [0:255];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MAX_BURST(8)
    ) dut (
        .clk(clk), .rst(rst),
        .gpp_req(gpp_req), .gpp_we(gpp_we),
        .gpp_addr(gpp_addr), .gpp_wdata(gpp_wdata),
        .gpp_gnt(gpp_gnt), .gpp_stall(gpp_stall),
        .gpp_rvalid(gpp_rvalid), .gpp_rdata(gpp_rdata),
        .cp_req(cp_req), .cp_we(cp_we),
        .cp_addr(cp_addr), .cp_wdata(cp_wdata),
        .cp_last(cp_last), .cp_gnt(cp_gnt),
        .cp_rvalid(cp_rvalid), .cp_rdata(cp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_gpp(input logic r, input logic w,
                           input logic [15:0] a);
        gpp_req  = r;
        gpp_we   = w;
        gpp_addr = a;
    endtask

    task automatic drv_cp(input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic l);
        cp_req   = r;
        cp_we    = w;
        cp_addr  = a;
        cp_wdata = d;
        cp_last  = l;
    endtask

    task automatic chk_gnt(input string tag, input logic g,
                           input logic c);
        check({tag, "_gpp_gnt"}, {31'd0, gpp_gnt}, {31'd0, g});
        check({tag, "_cp_gnt"}, {31'd0, cp_gnt}, {31'd0, c});
        check({tag, "_stall"}, {31'd0, gpp_stall},
              {31'd0, gpp_req & ~g});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h40] = 16'h1234;
        mem[8'h41] = 16'h5678;
        mem[8'h42] = 16'h9abc;
        mem_rdata  = 16'h0;
        gpp_wdata  = 16'hbeef;

        // Reset held with both requesting: nothing may reach memory.
        rst = 1'b0;
        drv_gpp(1'b1, 1'b1, 16'h0040);
        drv_cp(1'b1, 1'b0, 16'h0020, 16'h0, 1'b1);
        @(negedge clk);
        check("rst_gpp_gnt", {31'd0, gpp_gnt}, 32'd0);
        check("rst_cp_gnt", {31'd0, cp_gnt}, 32'd0);
        check("rst_gpp_rvalid", {31'd0, gpp_rvalid}, 32'd0);
        check("rst_cp_rvalid", {31'd0, cp_rvalid}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);

        // Release: last_owner resets to CP, so GPP wins the conflict.
        next_cyc();
        rst = 1'b1;
        drv_gpp(1'b1, 1'b0, 16'h0040);
        @(negedge clk);
        chk_gnt("rel", 1'b1, 1'b0);
        check("rel_mem_addr", {16'd0, mem_addr}, 32'h40);
        check("rel_mem_we", {31'd0, mem_we}, 32'd0);

        // Idle cycle: read data returns, memory port parked at zero.
        next_cyc();
        drv_gpp(1'b0, 1'b0, 16'h0040);
        drv_cp(1'b0, 1'b0, 16'h0020, 16'h0, 1'b1);
        @(negedge clk);
        check("idle_gpp_rvalid", {31'd0, gpp_rvalid}, 32'd1);
        check("idle_gpp_rdata", {16'd0, gpp_rdata}, 32'h1234);
        check("idle_cp_rvalid", {31'd0, cp_rvalid}, 32'd0);
        check("idle_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("idle_mem_we", {31'd0, mem_we}, 32'd0);

        // Single GPP read of 0x41.
        next_cyc();
        drv_gpp(1'b1, 1'b0, 16'h0041);
        @(negedge clk);
        chk_gnt("sgl", 1'b1, 1'b0);

        // Single CP read of 0x42, GPP data from 0x41 returns.
        next_cyc();
        drv_gpp(1'b0, 1'b0, 16'h0041);
        drv_cp(1'b1, 1'b0, 16'h0042, 16'h0, 1'b1);
        @(negedge clk);
        chk_gnt("cps", 1'b0, 1'b1);
        check("sgl_rvalid", {31'd0, gpp_rvalid}, 32'd1);
        check("sgl_rdata", {16'd0, gpp_rdata}, 32'h5678);
        check("cps_mem_addr", {16'd0, mem_addr}, 32'h42);

        // Conflict alternation, last owner CP: GPP, CP, GPP, CP.
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            drv_gpp(1'b1, 1'b0, 16'h0040);
            drv_cp(1'b1, 1'b0, 16'h0042, 16'h0, 1'b1);
            @(negedge clk);
            chk_gnt($sformatf("alt%0d", i), (i % 2) == 0, (i % 2) == 1);
            if (i == 0) begin
                check("cps_rvalid", {31'd0, cp_rvalid}, 32'd1);
                check("cps_rdata", {16'd0, cp_rdata}, 32'h9abc);
            end
        end

        // GPP alone so that CP wins the next conflict.
        next_cyc();
        drv_cp(1'b0, 1'b0, 16'h0042, 16'h0, 1'b1);
        @(negedge clk);
        chk_gnt("pre_burst", 1'b1, 1'b0);

        // Four-beat CP write burst with GPP requesting throughout.
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            drv_gpp(1'b1, 1'b0, 16'h0083);
            drv_cp(1'b1, 1'b1, 16'h0080 + 16'(i),
                   16'h0100 + 16'(i), i == 3);
            @(negedge clk);
            chk_gnt($sformatf("bst%0d", i), 1'b0, 1'b1);
            check($sformatf("bst%0d_we", i), {31'd0, mem_we}, 32'd1);
            check($sformatf("bst%0d_wd", i), {16'd0, mem_wdata},
                  32'h0100 + i);
        end

        // Burst done: GPP reads back the last beat.
        next_cyc();
        drv_cp(1'b0, 1'b0, 16'h0042, 16'h0, 1'b0);
        @(negedge clk);
        chk_gnt("post_burst", 1'b1, 1'b0);
        check("bst_cp_rvalid", {31'd0, cp_rvalid}, 32'd0);

        // Burst cap: cp_last never set, both requesting.
        for (int i = 0; i < 10; i++) begin
            next_cyc();
            drv_gpp(1'b1, 1'b0, 16'h0040);
            drv_cp(1'b1, 1'b0, 16'h0042, 16'h0, 1'b0);
            @(negedge clk);
            chk_gnt($sformatf("cap%0d", i), i == 8, i != 8);
            if (i == 0) begin
                check("post_rvalid", {31'd0, gpp_rvalid}, 32'd1);
                check("post_rdata", {16'd0, gpp_rdata}, 32'h0103);
            end
        end

        // Abort: the CP beat above was beat 1, one more, then req drops.
        next_cyc();
        @(negedge clk);
        chk_gnt("abt_b2", 1'b0, 1'b1);
        next_cyc();
        cp_req = 1'b0;
        @(negedge clk);
        chk_gnt("abt_drop", 1'b0, 1'b0);
        next_cyc();
        cp_req = 1'b1;
        @(negedge clk);
        chk_gnt("abt_gpp", 1'b1, 1'b0);

        // Mid-burst reset during beat 3.
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            drv_gpp(1'b0, 1'b0, 16'h0040);
            drv_cp(1'b1, 1'b0, 16'h0042, 16'h0, 1'b0);
            @(negedge clk);
            chk_gnt($sformatf("mrb%0d", i), 1'b0, 1'b1);
        end
        check("mrb_rvalid_pre", {31'd0, cp_rvalid}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mrb_cp_gnt", {31'd0, cp_gnt}, 32'd0);
        check("mrb_cp_rvalid", {31'd0, cp_rvalid}, 32'd0);

        // Released in IDLE with last_owner=CP: GPP wins.
        next_cyc();
        rst = 1'b1;
        drv_gpp(1'b1, 1'b0, 16'h0040);
        @(negedge clk);
        chk_gnt("mrb_rel", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data memory between the GPP datapath load/store port and the communications processor.
- The communications processor uses the memory for RX buffer writes and TX buffer reads.
- Arbitrates per cycle with alternating priority on conflict, and supports locked communications-processor bursts.
- Generates the GPP stall signal, and routes registered read-valid flags to the requester that issued each read.

Parameters:
- ADDR_W, 16, address width of data memory and both requesters
- DATA_W, 16, data width
- MAX_BURST, 8, maximum locked communications-processor beats per burst (>=1; 1 disables bursts)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- gpp_req  in  1  GPP memory access request
- gpp_we  in  1  GPP write (1) / read (0)
- gpp_addr  in  ADDR_W  GPP address
- gpp_wdata  in  DATA_W  GPP write data
- gpp_gnt  out  1  GPP access performed this cycle
- gpp_stall  out  1  GPP must hold PC and pipeline
- gpp_rvalid  out  1  GPP read data valid
- gpp_rdata  out  DATA_W  GPP read data
- cp_req  in  1  comms processor request
- cp_we  in  1  comms processor write/read
- cp_addr  in  ADDR_W  comms processor address
- cp_wdata  in  DATA_W  comms processor write data
- cp_last  in  1  final beat of comms processor burst
- cp_gnt  out  1  comms processor access performed this cycle
- cp_rvalid  out  1  comms processor read data valid
- cp_rdata  out  DATA_W  comms processor read data
- mem_addr  out  ADDR_W  data memory address
- mem_we  out  1  data memory write enable
- mem_wdata  out  DATA_W  data memory write data
- mem_rdata  in  DATA_W  data memory read data, valid cycle after the read address

Behaviour:
- Registered state:
  - FSM state {IDLE, CP_BURST}
  - last_owner (GPP/CP)
  - beat_cnt, width clog2(MAX_BURST)+1
  - gpp_rvalid, cp_rvalid
- Reset (rst=0, async): state=IDLE, last_owner=CP, beat_cnt=0, gpp_rvalid=cp_rvalid=0. Reset mid-burst abandons the burst immediately.
- Grants are combinational from state and requests. At most one of gpp_gnt/cp_gnt is high; each grant requires its own req high.
- IDLE grant rules:
  - only one requester: grant it.
  - both requesting: grant the requester that is not last_owner.
  - no request: no grant.
- IDLE with a CP grant and cp_last=0 and MAX_BURST>1: next state=CP_BURST, beat_cnt=1.
- CP_BURST:
  - cp_gnt=cp_req and gpp_gnt=0 regardless of gpp_req.
  - Each granted beat increments beat_cnt.
  - Return to IDLE when a granted beat has cp_last=1, or when that beat makes beat_cnt==MAX_BURST.
  - Also return to IDLE, with no grant that cycle, if cp_req=0 (burst aborted).
- last_owner updates on every granted cycle to the granted requester.
- Memory drive:
  - the granted requester's addr, we and wdata go to the memory ports.
  - no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - gpp_rvalid(next) = gpp_gnt & ~gpp_we; cp_rvalid(next) = cp_gnt & ~cp_we.
  - gpp_rdata=cp_rdata=mem_rdata (passthrough); data is qualified only by rvalid.
  - Read latency is 1 cycle after grant.
- gpp_stall = gpp_req & ~gpp_gnt, combinational. The GPP must hold req/addr/we/wdata stable while stalled.
- Writes complete in the grant cycle. No write response.
- Starvation bound:
  - GPP waits at most MAX_BURST cycles.
  - The comms processor waits at most 1 cycle once the GPP has been served.

Test Plan:
- Reset: rst=0 with both requests high -> all grants, rvalids and mem_we = 0. Release rst -> GPP granted first (last_owner=CP).
- Single GPP read: gpp_req=1, gpp_we=0, gpp_addr=16'h0040, memory holds 16'h1234 -> gpp_gnt same cycle, gpp_rvalid=1 with gpp_rdata=16'h1234 next cycle, gpp_stall=0.
- Conflict alternation: both requesting single beats (cp_last=1) for 4 cycles -> grants GPP, CP, GPP, CP. gpp_stall=1 on CP cycles.
- CP burst: cp writes 16'h0100..0x0103 with cp_last on beat 4, gpp_req=1 throughout -> 4 consecutive cp_gnt, gpp_stall=1 for 4 cycles, GPP granted on cycle 5.
- Burst cap: MAX_BURST=8, cp_last never asserted, both requesting -> cp_gnt for exactly 8 cycles, then gpp_gnt, then CP resumes.
- Abort and mid-burst reset: cp_req drops after beat 2 -> IDLE, GPP granted next. Separately, rst=0 asserted during beat 3 -> cp_gnt and cp_rvalid drop at once, state IDLE after release.
